opb_register_simulink2ppc: RTL and testbench
============================================

Name: opb_register_simulink2ppc

Overview:
OPB slave that returns a fabric-produced (Simulink) 32-bit value to the PowerPC. It is the PPC-read counterpart of the PPC-to-Simulink software register. User logic presents a word with a valid strobe. The block holds it in a capture register and exposes data, sticky status flags and a capture counter at three OPB word offsets. It shares a single clock with the bus.

Parameters:
C_BASEADDR, 32'h01001200, first byte address of the decoded window
C_HIGHADDR, 32'h010012FF, last byte address of the decoded window
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width; only 32 is supported
C_FAMILY, "virtex5", target family; carried for the tool flow, no functional effect

Ports:
OPB_Clk  in  1  sole clock; bus and user logic both run on it
OPB_Rst  in  1  synchronous reset, active-low
Sl_DBus  out  [0:31]  read data; zero whenever Sl_xferAck=0 (OPB OR-bus)
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
Sl_xferAck  out  1  one-cycle transfer acknowledge
OPB_ABus  in  [0:31]  address
OPB_BE  in  [0:3]  byte enables
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1=read, 0=write
OPB_select  in  1  master has bus cycle in progress
OPB_seqAddr  in  1  ignored
user_data_in  in  [31:0]  value from fabric
user_data_valid  in  1  capture strobe, one cycle per word

Behaviour:
- Reset (OPB_Rst=0 at a clock edge):
  - All outputs 0.
  - data_reg=0, count=0, new_data=0, overrun=0.
  - FSM returns to IDLE, aborting any transaction in progress; no ack is issued for it.
- Bit mapping: internal bit k maps to OPB bit 31-k.
  - Sl_DBus[31-k]=rd_word[k].
  - OPB_DBus[31-k] maps to write bit k.
  - OPB_BE[3] covers bits 7:0.
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Word offset is OPB_ABus[28:29] relative to base.
  - Offset 0x0, DATA (RO): data_reg.
  - Offset 0x4, STATUS: bit0=new_data, bit1=overrun, other bits read 0. Write-1-to-clear on bits 1:0, gated by OPB_BE[3].
  - Offset 0x8, COUNT (RO): 32-bit capture count, wraps 0xFFFFFFFF -> 0.
  - Offset 0xC: reads 0.
  - Writes to RO offsets and to 0xC are acked and ignored.
- FSM states: IDLE, DECODE, ACK, WAIT.
  - IDLE -> DECODE on a hit. In DECODE, offset and RNW are registered and the read word is snapshotted.
  - DECODE -> ACK. In ACK, Sl_xferAck=1 for exactly one cycle and Sl_DBus carries the snapshot on reads.
  - ACK -> WAIT. WAIT -> IDLE when OPB_select=0.
  - Ack latency is 2 cycles after the first cycle of OPB_select. At most one ack is issued per select assertion.
  - If select drops during DECODE, go to IDLE and issue no ack.
- Capture: when user_data_valid=1, data_reg<=user_data_in, count<=count+1 and new_data<=1.
  - If new_data is already 1 and is not being cleared in the same cycle, overrun<=1.
- Read-clear: a DATA read clears new_data in its ACK cycle.
  - If user_data_valid=1 in that same cycle, set wins: new_data stays 1, overrun is unchanged, and the returned data is the DECODE snapshot (the pre-update value).
- W1C on STATUS applies in the ACK cycle.
  - If new_data is being set in the same cycle, set wins.
  - If overrun is being set in the same cycle, set wins.
- Reset mid-transaction: the master sees no ack and times out. The bench drives OPB_select low afterwards.

Decomposition:
- Package opb_reg_pkg holds:
  - offset constants REG_DATA=2'd0, REG_STATUS=2'd1, REG_COUNT=2'd2;
  - FSM state typedef {IDLE, DECODE, ACK, WAIT};
  - STATUS bit indices.
- One sub-module is natural: opb_slave_if. It contains the address decode, the FSM and the ack/DBus gating, and is reusable by the ppc2simulink register.
- The top level keeps the capture register, flags and counter.

Test Plan:
- Reset, then read DATA at 0x01001200: Sl_xferAck high on the 2nd cycle after select, Sl_DBus=0x00000000.
- Strobe user_data_in=0x12345678, then read DATA: returns 0x12345678. Then read STATUS: returns 0x0 (new_data cleared by the DATA read). Read COUNT: returns 1.
- Two strobes (0xA, 0xB) with no read in between: DATA=0xB, STATUS=0x3. Write 0x2 to STATUS with BE=1111, then STATUS=0x1. Write 0x1, then STATUS=0x0.
- user_data_valid=1 coinciding with the DATA-read ACK cycle: returns the old value, STATUS new_data=1, overrun=0.
- Address 0x01001300 (outside window) with select held 5 cycles: no Sl_xferAck, Sl_DBus stays 0.
- Preload count near wrap, e.g. 0xFFFFFFFF strobes or a forced counter: the next strobe gives COUNT=0.
- Assert OPB_Rst=0 during DECODE: no ack, all registers 0. A following read succeeds normally.

Source files
------------

// File: rtl/opb_register_simulink2ppc_pkg.sv
// opb_reg_pkg: register offsets, status bit positions and slave FSM states
package opb_reg_pkg;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam int ST_NEW = 0;
  localparam int ST_OVR = 1;
  typedef enum logic [1:0] {IDLE, DECODE, ACK, WAIT} state_t;
endpackage

// File: rtl/opb_register_simulink2ppc_if.sv
// opb_register_simulink2ppc_if: OPB slave-side bus signals, OPB big-endian bit numbering
interface opb_register_simulink2ppc_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic        Sl_xferAck;
  modport master (output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
                  input Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck);
  modport slave  (input OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
                  output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck);
endinterface

// File: rtl/opb_register_simulink2ppc_slave.sv
// opb_slave_if: window decode, IDLE/DECODE/ACK/WAIT handshake, read snapshot and OR-bus gating
module opb_slave_if
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0100_1200,
  parameter logic [31:0] C_HIGHADDR = 32'h0100_12FF
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  opb_register_simulink2ppc_if.slave        opb,
  input  logic [31:0]                       i_rd_word,
  output logic [1:0]                        o_addr_off,
  output logic [1:0]                        o_off,
  output logic                              o_rnw,
  output logic                              o_ack
);
  state_t      r_state, w_next;
  logic [31:0] w_addr, r_rdata;
  logic        w_hit;
  assign w_addr     = opb.OPB_ABus;
  assign w_hit      = opb.OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
  assign o_addr_off = w_addr[3:2] - C_BASEADDR[3:2];
  assign o_ack      = (r_state == ACK);
  assign opb.Sl_xferAck = o_ack;
  assign opb.Sl_DBus    = (o_ack && o_rnw) ? r_rdata : 32'd0;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;
  // state register; reset aborts any transfer without acking it
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end
  // latch offset, direction and the read word while decoding
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_off   <= 2'd0;
      o_rnw   <= 1'b0;
      r_rdata <= 32'd0;
    end else if (r_state == DECODE) begin
      o_off   <= o_addr_off;
      o_rnw   <= opb.OPB_RNW;
      r_rdata <= i_rd_word;
    end
  end
  // next state: one ack per select, dropped select in DECODE abandons the cycle
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE)   ? (w_hit ? DECODE : IDLE) :
             (r_state == DECODE) ? (opb.OPB_select ? ACK : IDLE) :
             (r_state == ACK)    ? WAIT :
                                   (opb.OPB_select ? WAIT : IDLE);
  end
endmodule

// File: rtl/opb_register_simulink2ppc.sv
// opb_register_simulink2ppc: captures a fabric word and exposes DATA/STATUS/COUNT to the PPC over OPB
module opb_register_simulink2ppc
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_1200,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_12FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  opb_register_simulink2ppc_if.slave  opb,
  input  logic [31:0]                 user_data_in,
  input  logic                        user_data_valid
);
  logic [31:0] r_data, r_count, w_rd_word;
  logic        r_new, r_ovr;
  logic [1:0]  w_addr_off, w_off, w_w1c;
  logic        w_rnw, w_ack, w_rd_clr, w_new_clr, w_ovr_set;
  logic        w_unused;
  opb_slave_if #(.C_BASEADDR(C_BASEADDR), .C_HIGHADDR(C_HIGHADDR)) u_slave (
    .i_clk(OPB_Clk), .i_rst_n(OPB_Rst), .opb(opb), .i_rd_word(w_rd_word),
    .o_addr_off(w_addr_off), .o_off(w_off), .o_rnw(w_rnw), .o_ack(w_ack)
  );
  assign w_unused  = ^{opb.OPB_seqAddr, opb.OPB_DBus[0:29], opb.OPB_BE[0:2],
                       C_OPB_AWIDTH[0], C_OPB_DWIDTH[0], C_FAMILY[0]};
  assign w_rd_word = (w_addr_off == REG_DATA)   ? r_data :
                     (w_addr_off == REG_STATUS) ? {30'd0, r_ovr, r_new} :
                     (w_addr_off == REG_COUNT)  ? r_count : 32'd0;
  assign w_rd_clr  = w_ack && w_rnw && (w_off == REG_DATA);
  assign w_w1c     = (w_ack && !w_rnw && (w_off == REG_STATUS) && opb.OPB_BE[3]) ? opb.OPB_DBus[30:31] : 2'b00;
  assign w_new_clr = w_rd_clr || w_w1c[ST_NEW];
  assign w_ovr_set = user_data_valid && r_new && !w_new_clr;
  // capture register, counter and sticky flags; a set always beats a clear
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst) begin
      r_data  <= 32'd0;
      r_count <= 32'd0;
      r_new   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (user_data_valid) begin
        r_data  <= user_data_in;
        r_count <= r_count + 32'd1;
      end
      r_new <= user_data_valid || (r_new && !w_new_clr);
      r_ovr <= w_ovr_set || (r_ovr && !w_w1c[ST_OVR]);
    end
  end
endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// tb_opb_register_simulink2ppc: directed OPB transfers with hand-computed expectations
module tb_opb_register_simulink2ppc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] udata = 32'd0;
  logic        uvalid = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  int          lat;
  logic [31:0] rd;

  localparam logic [31:0] A_DATA = 32'h0100_1200;
  localparam logic [31:0] A_STAT = 32'h0100_1204;
  localparam logic [31:0] A_CNT  = 32'h0100_1208;

  opb_register_simulink2ppc_if opb ();

  opb_register_simulink2ppc dut (
    .OPB_Clk(clk), .OPB_Rst(rst_n), .opb(opb),
    .user_data_in(udata), .user_data_valid(uvalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [31:0] addr, input logic rnw, input logic [31:0] wdata,
                     input logic [3:0] be, input bit strobe, input logic [31:0] sdata,
                     output int l, output logic [31:0] data);
    l = -1;
    data = 32'hxxxx_xxxx;
    opb.OPB_ABus = addr;
    opb.OPB_RNW = rnw;
    opb.OPB_DBus = wdata;
    opb.OPB_BE = be;
    opb.OPB_select = 1'b1;
    for (int n = 0; n < 6 && l < 0; n++) begin
      @(negedge clk);
      if (opb.Sl_xferAck === 1'b1) begin
        l = n;
        data = opb.Sl_DBus;
        if (strobe) begin
          udata = sdata;
          uvalid = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    opb.OPB_select = 1'b0;
    uvalid = 1'b0;
    @(negedge clk);
    check("ack one cycle", {31'd0, opb.Sl_xferAck}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus(addr, 1'b1, 32'd0, 4'hF, 1'b0, 32'd0, lat, rd);
    check({tag, " latency"}, 32'(lat), 32'd2);
    check(tag, rd, exp);
  endtask

  task automatic wrchk(input string tag, input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
    bus(addr, 1'b0, d, be, 1'b0, 32'd0, lat, rd);
    check({tag, " latency"}, 32'(lat), 32'd2);
  endtask

  task automatic strobe(input logic [31:0] d);
    udata = d;
    uvalid = 1'b1;
    @(posedge clk); #1;
    uvalid = 1'b0;
  endtask

  initial begin
    opb.OPB_ABus = 32'd0;
    opb.OPB_BE = 4'd0;
    opb.OPB_DBus = 32'd0;
    opb.OPB_RNW = 1'b0;
    opb.OPB_select = 1'b0;
    opb.OPB_seqAddr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ack", {31'd0, opb.Sl_xferAck}, 32'd0);
    check("reset dbus", opb.Sl_DBus, 32'd0);
    check("reset err/retry/tout", {29'd0, opb.Sl_errAck, opb.Sl_retry, opb.Sl_toutSup}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    rdchk("data after reset", A_DATA, 32'h0000_0000);

    strobe(32'h1234_5678);
    rdchk("data first", A_DATA, 32'h1234_5678);
    rdchk("status after data read", A_STAT, 32'h0);
    rdchk("count one", A_CNT, 32'd1);

    strobe(32'hA);
    strobe(32'hB);
    rdchk("status overrun", A_STAT, 32'h3);
    wrchk("w1c overrun", A_STAT, 32'h2, 4'hF);
    rdchk("status after w1c ovr", A_STAT, 32'h1);
    wrchk("w1c new", A_STAT, 32'h1, 4'hF);
    rdchk("status after w1c new", A_STAT, 32'h0);
    rdchk("data B", A_DATA, 32'hB);
    rdchk("count three", A_CNT, 32'd3);

    strobe(32'hC);
    bus(A_DATA, 1'b1, 32'd0, 4'hF, 1'b1, 32'hD, lat, rd);
    check("race latency", 32'(lat), 32'd2);
    check("race old data", rd, 32'hC);
    rdchk("race status set wins", A_STAT, 32'h1);
    rdchk("count five", A_CNT, 32'd5);

    wrchk("w1c be gated", A_STAT, 32'h3, 4'hE);
    rdchk("status be gated", A_STAT, 32'h1);
    wrchk("write ro data", A_DATA, 32'hFFFF_FFFF, 4'hF);
    wrchk("write offset c", 32'h0100_120C, 32'hFFFF_FFFF, 4'hF);
    rdchk("data D", A_DATA, 32'hD);
    rdchk("status cleared", A_STAT, 32'h0);
    rdchk("offset c", 32'h0100_120C, 32'h0);

    opb.OPB_ABus = 32'h0100_1300;
    opb.OPB_RNW = 1'b1;
    opb.OPB_select = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("miss ack", {31'd0, opb.Sl_xferAck}, 32'd0);
      check("miss dbus", opb.Sl_DBus, 32'd0);
    end
    @(posedge clk); #1;
    opb.OPB_select = 1'b0;
    @(posedge clk); #1;

    force dut.r_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_count;
    @(posedge clk); #1;
    strobe(32'hE);
    rdchk("count wrap", A_CNT, 32'd0);
    rdchk("data E", A_DATA, 32'hE);

    strobe(32'hF);
    opb.OPB_ABus = A_DATA;
    opb.OPB_RNW = 1'b1;
    opb.OPB_select = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("decode no ack", {31'd0, opb.Sl_xferAck}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    opb.OPB_select = 1'b0;
    @(negedge clk);
    check("reset abort ack", {31'd0, opb.Sl_xferAck}, 32'd0);
    check("reset abort dbus", opb.Sl_DBus, 32'd0);
    @(posedge clk); #1;
    rdchk("data after abort", A_DATA, 32'h0);
    rdchk("status after abort", A_STAT, 32'h0);
    rdchk("count after abort", A_CNT, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
